memd_arb: RTL and testbench

Two-requester arbiter and sequencer in front of the single-ported data memory (`memd_1`) in the simpleooo_1cycle core. It shares the memory between the speculative load path and the in-order store-commit path. Each cycle it grants at most one request and drives the memory port. It returns load data and store completion one cycle later, and drops load responses squashed by a pipeline flush.

---
 rtl/memd_arb.sv | 152 +++++++++++++++
 tb/tb_memd_arb.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/memd_arb.sv
// Arbiter/sequencer sharing the single-ported data memory between speculative loads and committed stores.
// Same-cycle memory drive, 1-cycle response; readies are combinational grants. Build option: MEMD_ARB_RR_EN (round-robin).
`ifndef MEMD_SIZE_LOG
`define MEMD_SIZE_LOG 8
`endif
`ifndef REG_LEN
`define REG_LEN 32
`endif

module memd_arb #(
    parameter int ADDR_W       = `MEMD_SIZE_LOG,
    parameter int DATA_W       = `REG_LEN,
    parameter int TAG_W        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ld_req_valid,
    output logic              ld_req_ready,
    input  logic [ADDR_W-1:0] ld_req_addr,
    input  logic [TAG_W-1:0]  ld_req_tag,
    output logic              ld_resp_valid,
    output logic [TAG_W-1:0]  ld_resp_tag,
    output logic [DATA_W-1:0] ld_resp_data,
    input  logic              st_req_valid,
    output logic              st_req_ready,
    input  logic [ADDR_W-1:0] st_req_addr,
    input  logic [DATA_W-1:0] st_req_data,
    output logic              st_done,
    output logic              mem_req_valid,
    output logic              mem_req_rdwt,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_data,
    input  logic [DATA_W-1:0] mem_resp_data
);

    logic w_ld_cand;
    logic w_st_cand;
    logic w_ld_wins;
    logic w_ld_gnt;
    logic w_st_gnt;

    logic              r_ld_vld;
    logic [TAG_W-1:0]  r_ld_tag;
    logic [DATA_W-1:0] r_ld_data;
    logic              r_st_done;

    assign w_ld_cand = ld_req_valid & ~flush & ~rst;
    assign w_st_cand = st_req_valid & ~rst;

`ifdef MEMD_ARB_RR_EN
    // 1 = load won the most recent grant, so the store is favoured next
    logic r_last_ld;

    assign w_ld_wins = ~r_last_ld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_ld <= 1'b1;
        end else if (w_ld_gnt) begin
            r_last_ld <= 1'b1;
        end else if (w_st_gnt) begin
            r_last_ld <= 1'b0;
        end
    end
`else
    localparam logic [0:0] ST_STORE_PRI = 1'b0;
    localparam logic [0:0] ST_LOAD_PRI  = 1'b1;
    localparam logic [3:0] LP_STARVE_LIMIT = 4'(STARVE_LIMIT);

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [3:0] r_starve;
    logic [3:0] w_starve_nxt;

    assign w_ld_wins = (r_state == ST_LOAD_PRI);

    always_comb begin
        w_starve_nxt = r_starve;
        if (flush || !ld_req_valid || w_ld_gnt) begin
            w_starve_nxt = 4'd0;
        end else if (r_starve != 4'hF) begin
            w_starve_nxt = r_starve + 4'd1;
        end
    end

    // Promotion keys off the updated count so the load wins on the very next cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_STORE_PRI: if (w_starve_nxt == LP_STARVE_LIMIT) w_state_nxt = ST_LOAD_PRI;
            ST_LOAD_PRI:  if (w_ld_gnt) w_state_nxt = ST_STORE_PRI;
            default:      w_state_nxt = ST_STORE_PRI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_STORE_PRI;
            r_starve <= 4'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
        end
    end
`endif

    assign w_ld_gnt = w_ld_cand & (~w_st_cand | w_ld_wins);
    assign w_st_gnt = w_st_cand & ~w_ld_gnt;

    assign ld_req_ready = w_ld_gnt;
    assign st_req_ready = w_st_gnt;

    // Idle port is parked as a read of address 0 so nothing is ever written by accident
    always_comb begin
        mem_req_valid = w_ld_gnt | w_st_gnt;
        mem_req_rdwt  = 1'b1;
        mem_req_addr  = '0;
        mem_req_data  = '0;
        if (w_ld_gnt) begin
            mem_req_addr = ld_req_addr;
        end else if (w_st_gnt) begin
            mem_req_rdwt = 1'b0;
            mem_req_addr = st_req_addr;
            mem_req_data = st_req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ld_vld  <= 1'b0;
            r_ld_tag  <= '0;
            r_ld_data <= '0;
            r_st_done <= 1'b0;
        end else begin
            r_ld_vld  <= w_ld_gnt;
            r_st_done <= w_st_gnt;
            if (w_ld_gnt) begin
                r_ld_tag  <= ld_req_tag;
                r_ld_data <= mem_resp_data;
            end
        end
    end

    // A response due in a flush or reset cycle belongs to squashed work and is dropped
    assign ld_resp_valid = r_ld_vld & ~flush & ~rst;
    assign ld_resp_tag   = r_ld_tag;
    assign ld_resp_data  = r_ld_data;
    assign st_done       = r_st_done & ~rst;

endmodule

// File: tb/tb_memd_arb.sv
// Directed bench for memd_arb: per-cycle vector table plus contention sequences, with a small memory model.
module tb_memd_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ld_req_valid;
    logic        ld_req_ready;
    logic [7:0]  ld_req_addr;
    logic [3:0]  ld_req_tag;
    logic        ld_resp_valid;
    logic [3:0]  ld_resp_tag;
    logic [31:0] ld_resp_data;
    logic        st_req_valid;
    logic        st_req_ready;
    logic [7:0]  st_req_addr;
    logic [31:0] st_req_data;
    logic        st_done;
    logic        mem_req_valid;
    logic        mem_req_rdwt;
    logic [7:0]  mem_req_addr;
    logic [31:0] mem_req_data;
    logic [31:0] mem_resp_data;

    logic [31:0] mem [0:255];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    memd_arb #(.ADDR_W(8), .DATA_W(32), .TAG_W(4), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready),
        .ld_req_addr(ld_req_addr), .ld_req_tag(ld_req_tag),
        .ld_resp_valid(ld_resp_valid), .ld_resp_tag(ld_resp_tag), .ld_resp_data(ld_resp_data),
        .st_req_valid(st_req_valid), .st_req_ready(st_req_ready),
        .st_req_addr(st_req_addr), .st_req_data(st_req_data), .st_done(st_done),
        .mem_req_valid(mem_req_valid), .mem_req_rdwt(mem_req_rdwt),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_resp_data(mem_resp_data)
    );

    // Memory model: combinational read, write at the clock edge
    assign mem_resp_data = mem[mem_req_addr];
    always @(posedge clk) begin
        if (mem_req_valid && !mem_req_rdwt) mem[mem_req_addr] <= mem_req_data;
    end

    typedef struct {
        logic        rst, flush, ld_v;
        logic [7:0]  ld_addr;
        logic [3:0]  ld_tag;
        logic        st_v;
        logic [7:0]  st_addr;
        logic [31:0] st_data;
        logic        e_ld_rdy, e_st_rdy, e_mvld, e_rdwt;
        logic [7:0]  e_maddr;
        logic [31:0] e_mdata;
        logic        e_rvld;
        logic [3:0]  e_rtag;
        logic [31:0] e_rdata;
        logic        e_sdone;
        logic        chk_pay;
    } vec_t;

    function automatic vec_t v(
        input logic r, input logic f, input logic lv, input logic [7:0] la, input logic [3:0] lt,
        input logic sv, input logic [7:0] sa, input logic [31:0] sd,
        input logic elr, input logic esr, input logic emv, input logic erw,
        input logic [7:0] ema, input logic [31:0] emd,
        input logic erv, input logic [3:0] ert, input logic [31:0] erd, input logic esd,
        input logic cp);
        vec_t x;
        x.rst = r; x.flush = f; x.ld_v = lv; x.ld_addr = la; x.ld_tag = lt;
        x.st_v = sv; x.st_addr = sa; x.st_data = sd;
        x.e_ld_rdy = elr; x.e_st_rdy = esr; x.e_mvld = emv; x.e_rdwt = erw;
        x.e_maddr = ema; x.e_mdata = emd;
        x.e_rvld = erv; x.e_rtag = ert; x.e_rdata = erd; x.e_sdone = esd; x.chk_pay = cp;
        return x;
    endfunction

    vec_t vecs [16];

    task automatic drive(input logic r, input logic f, input logic lv, input logic [7:0] la,
                         input logic [3:0] lt, input logic sv, input logic [7:0] sa,
                         input logic [31:0] sd);
        rst = r; flush = f;
        ld_req_valid = lv; ld_req_addr = la; ld_req_tag = lt;
        st_req_valid = sv; st_req_addr = sa; st_req_data = sd;
    endtask

    // One contended (or store-only) cycle: checks the grant and last cycle's completions
    logic prev_ld, prev_st;
    task automatic cont(input string name, input int c, input logic lv, input logic e_ld);
        logic e_st;
        e_st = ~e_ld;
        drive(1'b0, 1'b0, lv, 8'h05, 4'(c), 1'b1, 8'h06, 32'(c));
        @(negedge clk);
        n_tests++;
        if ({ld_req_ready, st_req_ready, mem_req_rdwt, ld_resp_valid, st_done} !==
            {e_ld, e_st, e_ld, prev_ld, prev_st}) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got ldrdy/strdy/rdwt/ldresp/stdone=%b%b%b%b%b, want %b%b%b%b%b",
                     name, c, ld_req_ready, st_req_ready, mem_req_rdwt, ld_resp_valid, st_done,
                     e_ld, e_st, e_ld, prev_ld, prev_st);
        end
        prev_ld = e_ld;
        prev_st = e_st;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [81:0] act, exp;
        logic        e_ld;
        logic        seq_lv [9];
        logic        seq_ld [9];

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        drive(1'b1, 1'b0, 1'b0, 8'h0, 4'h0, 1'b0, 8'h0, 32'h0);

        //           rst f lv lad   ltag  sv sad   sdata          lr sr mv rw mad   mdata          rv rtag  rdata          sd cp
        vecs[0]  = v(1, 0, 1, 8'h05, 4'h1, 1, 8'h02, 32'h11,        0, 0, 0, 1, 8'h00, 32'h0,        0, 4'h0, 32'h0,        0, 1);
        vecs[1]  = v(0, 0, 0, 8'h00, 4'h0, 0, 8'h00, 32'h0,         0, 0, 0, 1, 8'h00, 32'h0,        0, 4'h0, 32'h0,        0, 1);
        vecs[2]  = v(0, 0, 1, 8'h05, 4'h3, 0, 8'h00, 32'h0,         1, 0, 1, 1, 8'h05, 32'h0,        0, 4'h0, 32'h0,        0, 1);
        vecs[3]  = v(0, 0, 0, 8'h00, 4'h0, 0, 8'h00, 32'h0,         0, 0, 0, 1, 8'h00, 32'h0,        1, 4'h3, 32'h0,        0, 1);
        vecs[4]  = v(0, 0, 0, 8'h00, 4'h0, 1, 8'h02, 32'hA5,        0, 1, 1, 0, 8'h02, 32'hA5,       0, 4'h3, 32'h0,        0, 1);
        vecs[5]  = v(0, 0, 0, 8'h00, 4'h0, 0, 8'h00, 32'h0,         0, 0, 0, 1, 8'h00, 32'h0,        0, 4'h3, 32'h0,        1, 1);
        vecs[6]  = v(0, 0, 0, 8'h00, 4'h0, 0, 8'h00, 32'h0,         0, 0, 0, 1, 8'h00, 32'h0,        0, 4'h3, 32'h0,        0, 1);
        vecs[7]  = v(0, 0, 1, 8'h02, 4'h7, 0, 8'h00, 32'h0,         1, 0, 1, 1, 8'h02, 32'h0,        0, 4'h3, 32'h0,        0, 1);
        vecs[8]  = v(0, 0, 1, 8'h05, 4'h8, 0, 8'h00, 32'h0,         1, 0, 1, 1, 8'h05, 32'h0,        1, 4'h7, 32'hA5,       0, 1);
        vecs[9]  = v(0, 0, 0, 8'h00, 4'h0, 0, 8'h00, 32'h0,         0, 0, 0, 1, 8'h00, 32'h0,        1, 4'h8, 32'h0,        0, 1);
        vecs[10] = v(0, 0, 1, 8'h02, 4'h9, 0, 8'h00, 32'h0,         1, 0, 1, 1, 8'h02, 32'h0,        0, 4'h8, 32'h0,        0, 1);
        vecs[11] = v(0, 1, 1, 8'h05, 4'hA, 1, 8'h03, 32'h1234,      0, 1, 1, 0, 8'h03, 32'h1234,     0, 4'h9, 32'hA5,       0, 1);
        vecs[12] = v(0, 0, 0, 8'h00, 4'h0, 0, 8'h00, 32'h0,         0, 0, 0, 1, 8'h00, 32'h0,        0, 4'h9, 32'hA5,       1, 1);
        vecs[13] = v(0, 0, 1, 8'h02, 4'hB, 0, 8'h00, 32'h0,         1, 0, 1, 1, 8'h02, 32'h0,        0, 4'h9, 32'hA5,       0, 1);
        vecs[14] = v(1, 0, 1, 8'h05, 4'hC, 1, 8'h04, 32'h77,        0, 0, 0, 1, 8'h00, 32'h0,        0, 4'h0, 32'h0,        0, 0);
        vecs[15] = v(0, 0, 0, 8'h00, 4'h0, 0, 8'h00, 32'h0,         0, 0, 0, 1, 8'h00, 32'h0,        0, 4'h0, 32'h0,        0, 1);

        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rst, vecs[i].flush, vecs[i].ld_v, vecs[i].ld_addr, vecs[i].ld_tag,
                  vecs[i].st_v, vecs[i].st_addr, vecs[i].st_data);
            @(negedge clk);
            act = {ld_req_ready, st_req_ready, mem_req_valid, mem_req_rdwt, mem_req_addr, mem_req_data,
                   ld_resp_valid, st_done, ld_resp_tag, ld_resp_data};
            exp = {vecs[i].e_ld_rdy, vecs[i].e_st_rdy, vecs[i].e_mvld, vecs[i].e_rdwt, vecs[i].e_maddr,
                   vecs[i].e_mdata, vecs[i].e_rvld, vecs[i].e_sdone, vecs[i].e_rtag, vecs[i].e_rdata};
            if (!vecs[i].chk_pay) begin
                act[35:0] = 36'h0;
                exp[35:0] = 36'h0;
            end
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL vec%0d: got %h, want %h (ldrdy,strdy,mvld,rdwt,maddr,mdata,rvld,sdone,rtag,rdata)",
                         i, act, exp);
            end
            @(posedge clk); #1;
        end

        // Continuous contention straight out of reset
        prev_ld = 1'b0;
        prev_st = 1'b0;
        for (int c = 0; c < 10; c++) begin
`ifdef MEMD_ARB_RR_EN
            e_ld = (c % 2) == 1;
`else
            e_ld = (c % 5) == 4;
`endif
            cont("contend", c, 1'b1, e_ld);
        end

`ifndef MEMD_ARB_RR_EN
        // A cycle without a load request restarts the starvation count
        seq_lv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        seq_ld = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int c = 0; c < 9; c++) begin
            cont("starve_clear", c, seq_lv[c], seq_ld[c]);
        end
`else
        seq_lv = '{default: 1'b0};
        seq_ld = '{default: 1'b0};
`endif

        drive(1'b0, 1'b0, 1'b0, 8'h0, 4'h0, 1'b0, 8'h0, 32'h0);
        @(negedge clk);
        n_tests++;
        if ({ld_resp_valid, st_done, mem_req_valid} !== {prev_ld, prev_st, 1'b0}) begin
            n_fail++;
            $display("FAIL drain: got ldresp/stdone/mvld=%b%b%b, want %b%b0",
                     ld_resp_valid, st_done, mem_req_valid, prev_ld, prev_st);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
